spi_byte_receiver: RTL and testbench

- SPI peripheral (mode 0, MSB first) that deserialises bytes from the external host MCU.
- Presents each byte to the downstream image buffer as a one-cycle write strobe with data.
- Shifts a status byte back on MISO during each frame.
- Sits directly upstream of the image buffer. byte_valid/byte_data/byte_ready connect to write_request/data_in/write_ready.

---
 rtl/spi_pkg.sv | 36 +++
 rtl/sync_edge_detect.sv | 38 +++
 rtl/spi_byte_receiver.sv | 147 ++++++++++++++
 tb/tb_spi_byte_receiver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and types for the SPI byte receiver and the logic around it.
package spi_pkg;

   // Clock polarity/phase: CPOL=0, CPHA=0 (sample on rise, shift on fall)
   localparam int SPI_MODE = 0;
   localparam int BYTE_W   = 8;

   // Levels the pins rest at between frames; the synchronisers reset to these
   localparam logic SCLK_IDLE = 1'b0;
   localparam logic CS_N_IDLE = 1'b1;
   localparam logic MOSI_IDLE = 1'b0;

   // Layout of the status byte returned to the host on MISO, MSB first
   typedef struct packed {
      logic       ready;
      logic       busy;
      logic       result_valid;
      logic       overflow;
      logic [3:0] reserved;
   } spi_status_t;

   // Builds a status byte with the reserved field held at zero
   function automatic spi_status_t make_status(input logic ready,
                                               input logic busy,
                                               input logic result_valid,
                                               input logic overflow);
      spi_status_t s;
      s.ready        = ready;
      s.busy         = busy;
      s.result_valid = result_valid;
      s.overflow     = overflow;
      s.reserved     = 4'h0;
      return s;
   endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser for one asynchronous pin, followed by a history
// flop and registered single-cycle rise/fall pulses. A raw pin edge shows up
// as a pulse STAGES+1 clk cycles later; level is aligned with the pulses.
module sync_edge_detect #(
   parameter int   STAGES = 2,     // at least 2
   parameter logic IDLE   = 1'b0   // reset level of every flop in the chain
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              hist;

   // Shift the pin through the chain and compare the settled value with its history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chain <= {STAGES{IDLE}};
         hist  <= IDLE;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the previous
         // value of its neighbour; blocking here would collapse the chain.
         chain <= {chain[STAGES-2:0], d};
         hist  <= chain[STAGES-1];
         rise  <=  chain[STAGES-1] & ~hist;
         fall  <= ~chain[STAGES-1] &  hist;
      end
   end

   assign level = hist;

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI mode 0 peripheral: deserialises MSB-first bytes from the host and hands
// each one to the image buffer as a one-cycle strobe, while shifting a status
// byte back on MISO. All outputs are registered.
module spi_byte_receiver
   import spi_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_WIDTH   = 7
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 sclk,
   input  logic                 cs_n,
   input  logic                 mosi,
   output logic                 miso,
   input  logic [BYTE_W-1:0]    tx_status,
   output logic [BYTE_W-1:0]    byte_data,
   output logic                 byte_valid,
   input  logic                 byte_ready,
   output logic                 frame_active,
   output logic [CNT_WIDTH-1:0] frame_byte_count,
   output logic                 overflow,
   input  logic                 clear_overflow
);

   localparam int BIT_CNT_W = $clog2(BYTE_W);
   localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(BYTE_W - 1);
   localparam int SETTLE_W  = SYNC_STAGES + 2;

   logic sclk_level_unused;
   logic sclk_rise, sclk_fall;
   logic cs_level, cs_rise, cs_fall;
   logic mosi_level;
   logic mosi_rise_unused, mosi_fall_unused;

   logic [BIT_CNT_W-1:0] bit_cnt;
   logic [BYTE_W-1:0]    rx_shift;
   logic [BYTE_W-1:0]    rx_next;
   logic [BYTE_W-1:0]    tx_shift;
   logic [SETTLE_W-1:0]  settle;
   logic                 armed;
   logic                 frame_start;

   sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE(SCLK_IDLE)) u_sync_sclk (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (sclk),
      .level (sclk_level_unused),
      .rise  (sclk_rise),
      .fall  (sclk_fall)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE(CS_N_IDLE)) u_sync_cs_n (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (cs_n),
      .level (cs_level),
      .rise  (cs_rise),
      .fall  (cs_fall)
   );

   sync_edge_detect #(.STAGES(SYNC_STAGES), .IDLE(MOSI_IDLE)) u_sync_mosi (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (mosi),
      .level (mosi_level),
      .rise  (mosi_rise_unused),
      .fall  (mosi_fall_unused)
   );

   // The synchronisers reset to idle, so a cs_n already low at reset release
   // looks like a fresh falling edge. Frames are only accepted once the chain
   // has flushed and cs_n has actually been seen high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         settle <= '0;
         armed  <= 1'b0;
      end else begin
         settle <= {settle[SETTLE_W-2:0], 1'b1};
         if (settle[SETTLE_W-1] && cs_level)
            armed <= 1'b1;
      end
   end

   assign frame_start = cs_fall & armed;
   assign rx_next     = {rx_shift[BYTE_W-2:0], mosi_level};

   // Frame control, receive shifter, byte hand-off and MISO shifter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_active     <= 1'b0;
         bit_cnt          <= '0;
         rx_shift         <= '0;
         tx_shift         <= '0;
         miso             <= 1'b0;
         byte_data        <= '0;
         byte_valid       <= 1'b0;
         frame_byte_count <= '0;
         overflow         <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         if (clear_overflow)
            overflow <= 1'b0;

         if (frame_start) begin
            frame_active     <= 1'b1;
            bit_cnt          <= '0;
            rx_shift         <= '0;
            frame_byte_count <= '0;
            tx_shift         <= tx_status;
            miso             <= tx_status[BYTE_W-1];
         end else if (cs_rise) begin
            // Any partial byte is simply abandoned in rx_shift
            frame_active <= 1'b0;
            bit_cnt      <= '0;
            miso         <= 1'b0;
         end else if (frame_active) begin
            if (sclk_rise) begin
               rx_shift <= rx_next;
               bit_cnt  <= bit_cnt + 1'b1;
               if (bit_cnt == LAST_BIT) begin
                  if (byte_ready) begin
                     byte_data  <= rx_next;
                     byte_valid <= 1'b1;
                     if (frame_byte_count != {CNT_WIDTH{1'b1}})
                        frame_byte_count <= frame_byte_count + 1'b1;
                  end else if (!clear_overflow) begin
                     overflow <= 1'b1;
                  end
               end
            end
            if (sclk_fall) begin
               // bit_cnt has wrapped to 0 after a full byte: restart with a
               // fresh copy of the status so every byte reports current state
               if (bit_cnt == '0) begin
                  tx_shift <= tx_status;
                  miso     <= tx_status[BYTE_W-1];
               end else begin
                  tx_shift <= {tx_shift[BYTE_W-2:0], 1'b0};
                  miso     <= tx_shift[BYTE_W-2];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_spi_byte_receiver.sv
// Directed bench for spi_byte_receiver: the host side is modelled with
// bit-banged SPI tasks and every expected value is written out by hand.
module tb_spi_byte_receiver;

   localparam int CNT_WIDTH = 7;
   localparam int HALF      = 60;   // sclk half period in ns (6 clk cycles)

   logic                 clk;
   logic                 rst_n;
   logic                 sclk;
   logic                 cs_n;
   logic                 mosi;
   logic                 miso;
   logic [7:0]           tx_status;
   logic [7:0]           byte_data;
   logic                 byte_valid;
   logic                 byte_ready;
   logic                 frame_active;
   logic [CNT_WIDTH-1:0] frame_byte_count;
   logic                 overflow;
   logic                 clear_overflow;

   int n_assert = 0;
   int n_fail   = 0;
   int b2b      = 0;
   logic prev_valid = 1'b0;
   logic [7:0] rx_q[$];

   spi_byte_receiver #(.SYNC_STAGES(2), .CNT_WIDTH(CNT_WIDTH)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .sclk             (sclk),
      .cs_n             (cs_n),
      .mosi             (mosi),
      .miso             (miso),
      .tx_status        (tx_status),
      .byte_data        (byte_data),
      .byte_valid       (byte_valid),
      .byte_ready       (byte_ready),
      .frame_active     (frame_active),
      .frame_byte_count (frame_byte_count),
      .overflow         (overflow),
      .clear_overflow   (clear_overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Collect every strobe and flag any back-to-back strobe
   always @(negedge clk) begin
      if (rst_n && byte_valid) begin
         rx_q.push_back(byte_data);
         if (prev_valid) b2b++;
      end
      prev_valid = rst_n & byte_valid;
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic spi_bit(input logic b, output logic m);
      mosi = b;
      #(HALF);
      m = miso;
      sclk = 1'b1;
      #(HALF);
      sclk = 1'b0;
   endtask

   task automatic spi_byte(input logic [7:0] d, output logic [7:0] m);
      logic bit_m;
      for (int i = 7; i >= 0; i--) begin
         spi_bit(d[i], bit_m);
         m[i] = bit_m;
      end
   endtask

   task automatic cs_begin();
      cs_n = 1'b0;
      #100;
   endtask

   task automatic cs_end();
      #60;
      cs_n = 1'b1;
      #100;
   endtask

   task automatic q_head(output logic [7:0] v);
      v = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
   endtask

   initial begin
      logic [7:0] m0, m1, d;
      logic       mb;

      rst_n = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
      tx_status = 8'h00; byte_ready = 1'b1; clear_overflow = 1'b0;
      #2;
      #50;
      check("rst_byte_data",  byte_data, 8'h00);
      check("rst_byte_valid", byte_valid, 0);
      check("rst_miso",       miso, 0);
      check("rst_frame_act",  frame_active, 0);
      check("rst_count",      frame_byte_count, 0);
      check("rst_overflow",   overflow, 0);
      rst_n = 1'b1;
      #100;

      // Single byte 0xA5
      rx_q.delete();
      cs_begin();
      check("a5_frame_active", frame_active, 1);
      spi_byte(8'hA5, m0);
      cs_end();
      check("a5_strobes", rx_q.size(), 1);
      q_head(d);
      check("a5_data_q",   d, 8'hA5);
      check("a5_data_out", byte_data, 8'hA5);
      check("a5_count",    frame_byte_count, 1);
      check("a5_overflow", overflow, 0);
      check("a5_frame_end", frame_active, 0);

      // 113 bytes 0x00..0x70 in one frame
      rx_q.delete();
      cs_begin();
      for (int i = 0; i < 113; i++) spi_byte(8'(i), m0);
      cs_end();
      check("img_strobes", rx_q.size(), 113);
      for (int i = 0; i < 113 && i < rx_q.size(); i++)
         check($sformatf("img_byte%0d", i), rx_q[i], 8'(i));
      check("img_count", frame_byte_count, 113);
      cs_begin();
      check("img_count_clr", frame_byte_count, 0);
      cs_end();

      // Dropped byte 0x3C raises overflow, byte_data keeps 0x11
      rx_q.delete();
      cs_begin();
      spi_byte(8'h11, m0);
      byte_ready = 1'b0;
      spi_byte(8'h3C, m0);
      cs_end();
      byte_ready = 1'b1;
      check("ovf_strobes", rx_q.size(), 1);
      check("ovf_data",    byte_data, 8'h11);
      check("ovf_set",     overflow, 1);
      check("ovf_count",   frame_byte_count, 1);
      clear_overflow = 1'b1;
      #10;
      clear_overflow = 1'b0;
      #20;
      check("ovf_clear", overflow, 0);

      // Status 0x81 shifted out twice
      tx_status = 8'h81;
      cs_begin();
      spi_byte(8'h00, m0);
      spi_byte(8'h00, m1);
      cs_end();
      check("miso_byte0", m0, 8'h81);
      check("miso_byte1", m1, 8'h81);
      check("miso_idle",  miso, 0);

      // Status change mid-byte only shows up in the following byte
      tx_status = 8'h81;
      cs_begin();
      for (int i = 7; i >= 0; i--) begin
         spi_bit(1'b0, mb);
         m0[i] = mb;
         if (i == 4) tx_status = 8'h3C;
      end
      spi_byte(8'h00, m1);
      cs_end();
      check("miso_chg_byte0", m0, 8'h81);
      check("miso_chg_byte1", m1, 8'h3C);

      // Partial byte (5 bits of ones) is dropped, next frame delivers 0x12
      rx_q.delete();
      cs_begin();
      for (int i = 0; i < 5; i++) spi_bit(1'b1, mb);
      cs_end();
      check("part_no_strobe", rx_q.size(), 0);
      cs_begin();
      spi_byte(8'h12, m0);
      cs_end();
      check("part_strobes", rx_q.size(), 1);
      q_head(d);
      check("part_data",  d, 8'h12);
      check("part_count", frame_byte_count, 1);
      check("part_ovf",   overflow, 0);

      // Reset in the middle of a frame with cs_n held low
      tx_status = 8'hFF;
      rx_q.delete();
      cs_begin();
      for (int i = 0; i < 4; i++) spi_bit(1'b1, mb);
      check("mid_miso_before", miso, 1);
      rst_n = 1'b0;
      #50;
      check("mid_rst_data",   byte_data, 8'h00);
      check("mid_rst_valid",  byte_valid, 0);
      check("mid_rst_miso",   miso, 0);
      check("mid_rst_active", frame_active, 0);
      check("mid_rst_count",  frame_byte_count, 0);
      rst_n = 1'b1;
      #200;
      spi_byte(8'hFF, m0);
      #100;
      check("mid_ignored",      rx_q.size(), 0);
      check("mid_still_idle",   frame_active, 0);
      check("mid_miso_quiet",   miso, 0);
      cs_n = 1'b1;
      #200;
      cs_begin();
      spi_byte(8'h5A, m0);
      cs_end();
      check("mid_strobes", rx_q.size(), 1);
      q_head(d);
      check("mid_data",  d, 8'h5A);
      check("mid_count", frame_byte_count, 1);

      // Byte counter saturates at all-ones
      rx_q.delete();
      cs_begin();
      for (int i = 0; i < 130; i++) spi_byte(8'(i), m0);
      cs_end();
      check("sat_strobes", rx_q.size(), 130);
      check("sat_count",   frame_byte_count, 7'h7F);

      check("no_back_to_back", b2b, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
